muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op and FSM
// encodings, iteration count and a small sign-magnitude helper.
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int unsigned ITER_COUNT = 32;
  localparam logic [5:0]  ITER_LAST  = 6'(ITER_COUNT - 1);

  // Bit 1 of the op selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational; the caller registers the returned accumulator.
module muldiv_step (
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  logic        div_mode,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    rem_sh   = acc[63:31];
    diff     = rem_sh - {1'b0, operand};
    acc_next = {sum, acc[31:1]};
    // Divide: {remainder, dividend} shifts left; quotient bits fill from the right.
    if (div_mode) begin
      if (rem_sh >= {1'b0, operand}) begin
        acc_next = {diff[31:0], acc[30:0], 1'b1};
      end else begin
        acc_next = {acc[62:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide with HI/LO result registers.
// Fixed 35-cycle latency (2 on divide-by-zero); stalls IF/ID on HI/LO reads or new starts while busy.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  input  logic        rd_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        stall
);

  state_e      state, state_nx;
  op_e         op_q;
  logic [31:0] rs_q, rt_q, operand_q;
  logic [63:0] acc, acc_step;
  logic [5:0]  cnt;
  logic        neg_lo, neg_hi, dbz_q;

  logic        signed_op, rs_neg, rt_neg, rt_zero;
  logic [31:0] mag_rs, mag_rt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  muldiv_step u_step (
    .acc      (acc),
    .operand  (operand_q),
    .div_mode (op_is_div(op_q)),
    .acc_next (acc_step)
  );

  always_comb begin
    signed_op = ~op_q[0];
    rs_neg    = signed_op & rs_q[31];
    rt_neg    = signed_op & rt_q[31];
    rt_zero   = (rt_q == 32'd0);
    mag_rs    = mag32(rs_q, rs_neg);
    mag_rt    = mag32(rt_q, rt_neg);
    // neg_lo covers both product sign and quotient sign; remainder follows the dividend.
    prod_fix  = neg_lo ? (64'd0 - acc) : acc;
    quo_fix   = mag32(acc[31:0], neg_lo);
    rem_fix   = mag32(acc[63:32], neg_hi);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = PREP;
      PREP: state_nx = (op_is_div(op_q) && rt_zero) ? DONE : ITER;
      ITER: if (cnt == ITER_LAST) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == PREP) || (state == ITER) || (state == FIX);
    done        = (state == DONE);
    div_by_zero = done & dbz_q;
    stall       = busy & (rd_hi | rd_lo | start);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_MULT;
      rs_q      <= 32'd0;
      rt_q      <= 32'd0;
      operand_q <= 32'd0;
      acc       <= 64'd0;
      cnt       <= 6'd0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      dbz_q     <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op_e'(op);
            rs_q <= rs_val;
            rt_q <= rt_val;
          end
        end
        PREP: begin
          // Multiply keeps the multiplier in the low word; divide keeps the dividend there.
          acc       <= {32'd0, op_is_div(op_q) ? mag_rs : mag_rt};
          operand_q <= op_is_div(op_q) ? mag_rt : mag_rs;
          neg_lo    <= rs_neg ^ rt_neg;
          neg_hi    <= rs_neg;
          dbz_q     <= op_is_div(op_q) && rt_zero;
          cnt       <= 6'd0;
        end
        ITER: begin
          acc <= acc_step;
          cnt <= (cnt == ITER_LAST) ? 6'd0 : cnt + 6'd1;
        end
        FIX: begin
          if (op_is_div(op_q)) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
